// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage - ALU, branch resolution, iterative MUL/DIVU/REMU,
//            and the EX-to-MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] EX_a,
    input  logic [XLEN-1:0] EX_b,
    input  logic [XLEN-1:0] EX_a2,
    input  logic [XLEN-1:0] EX_b2,
    input  logic [3:0]      EX_alu_op,
    input  logic            EX_brn,
    input  logic [4:0]      EX_rd,
    input  logic            EX_ld,
    input  logic            EX_str,
    input  logic            EX_we,
    input  logic            stall_M,
    output logic            EX_taken,
    output logic [XLEN-1:0] EX_target,
    output logic            stall_EX,
    output logic [XLEN-1:0] M_res,
    output logic [XLEN-1:0] M_sd,
    output logic [4:0]      M_rd,
    output logic            M_ld,
    output logic            M_str,
    output logic            M_we
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = SHW + 1;
    localparam logic [CNTW-1:0] C_STEPS = CNTW'(XLEN);
    localparam logic [CNTW-1:0] C_LAST  = CNTW'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Single-cycle ALU and branch compare
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_alu;
    logic [SHW-1:0]  w_shamt;
    logic            w_slt;
    logic            w_sltu;
    logic            w_cond;

    assign w_sum   = EX_a + EX_b;
    assign w_shamt = EX_b[SHW-1:0];
    assign w_slt   = $signed(EX_a) < $signed(EX_b);
    assign w_sltu  = EX_a < EX_b;

    always_comb begin
        w_alu = '0;
        case (EX_alu_op)
            OP_ADD:  w_alu = w_sum;
            OP_SUB:  w_alu = EX_a - EX_b;
            OP_AND:  w_alu = EX_a & EX_b;
            OP_OR:   w_alu = EX_a | EX_b;
            OP_XOR:  w_alu = EX_a ^ EX_b;
            OP_SLL:  w_alu = EX_a << w_shamt;
            OP_SRL:  w_alu = EX_a >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(EX_a) >>> w_shamt);
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_sltu};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (EX_alu_op)
            4'd0:    w_cond = (EX_a2 == EX_b2);
            4'd1:    w_cond = (EX_a2 != EX_b2);
            4'd2:    w_cond = ($signed(EX_a2) <  $signed(EX_b2));
            4'd3:    w_cond = ($signed(EX_a2) >= $signed(EX_b2));
            4'd4:    w_cond = (EX_a2 <  EX_b2);
            4'd5:    w_cond = (EX_a2 >= EX_b2);
            4'd6:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign EX_target = w_sum;
    assign EX_taken  = EX_brn & w_cond & ~stall_M;

    // ------------------------------------------------------------------
    // Iterative multiply / divide unit
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            mul_q, mul_d;
    logic            rem_q, rem_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;

    logic            w_is_mdu;
    logic            w_start;
    logic [XLEN:0]   w_rem_sh;
    logic            w_fits;
    logic [XLEN-1:0] w_mdu_res;

    assign w_is_mdu = ~EX_brn & ((EX_alu_op == OP_MUL) | (EX_alu_op == OP_DIVU) |
                                 (EX_alu_op == OP_REMU));
    assign w_start  = (state_q == S_IDLE) & w_is_mdu & ~stall_M;
    assign stall_EX = stall_M | w_start | (state_q == S_BUSY);

    // Restoring divide: a_q shifts the dividend out and the quotient in.
    assign w_rem_sh  = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    assign w_fits    = (w_rem_sh >= {1'b0, b_q});
    assign w_mdu_res = (mul_q | rem_q) ? acc_q[XLEN-1:0] : a_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        rem_d   = rem_q;
        we_d    = we_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    a_d     = EX_a;
                    b_d     = EX_b;
                    acc_d   = '0;
                    cnt_d   = C_STEPS;
                    mul_d   = (EX_alu_op == OP_MUL);
                    rem_d   = (EX_alu_op == OP_REMU);
                    we_d    = EX_we;
                    rd_d    = EX_rd;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!stall_M) begin
                    if (mul_q) begin
                        acc_d = acc_q + (b_q[0] ? {1'b0, a_q} : '0);
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end else begin
                        acc_d = w_fits ? (w_rem_sh - {1'b0, b_q}) : w_rem_sh;
                        a_d   = {a_q[XLEN-2:0], w_fits};
                    end
                    cnt_d = cnt_q - C_LAST;
                    if (cnt_q == C_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!stall_M) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            rem_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // EX-to-MEM register
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_res_q;
    logic [XLEN-1:0] m_sd_q;
    logic [4:0]      m_rd_q;
    logic            m_ld_q;
    logic            m_str_q;
    logic            m_we_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_res_q <= '0;
            m_sd_q  <= '0;
            m_rd_q  <= '0;
            m_ld_q  <= 1'b0;
            m_str_q <= 1'b0;
            m_we_q  <= 1'b0;
        end else if (!stall_M) begin
            if (state_q == S_DONE) begin
                m_res_q <= w_mdu_res;
                m_sd_q  <= '0;
                m_rd_q  <= rd_q;
                m_ld_q  <= 1'b0;
                m_str_q <= 1'b0;
                m_we_q  <= we_q;
            end else if (stall_EX) begin
                // Multi-cycle op in flight: push a bubble downstream.
                m_res_q <= '0;
                m_sd_q  <= '0;
                m_rd_q  <= '0;
                m_ld_q  <= 1'b0;
                m_str_q <= 1'b0;
                m_we_q  <= 1'b0;
            end else begin
                m_res_q <= (EX_brn | EX_ld | EX_str) ? w_sum : w_alu;
                m_sd_q  <= EX_b2;
                m_rd_q  <= EX_rd;
                m_ld_q  <= EX_ld;
                m_str_q <= EX_str;
                m_we_q  <= EX_we;
            end
        end
    end

    assign M_res = m_res_q;
    assign M_sd  = m_sd_q;
    assign M_rd  = m_rd_q;
    assign M_ld  = m_ld_q;
    assign M_str = m_str_q;
    assign M_we  = m_we_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    localparam int XLEN = 32;
    localparam int MDU_STALL = XLEN + 1;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] EX_a, EX_b, EX_a2, EX_b2;
    logic [3:0]      EX_alu_op;
    logic            EX_brn, EX_ld, EX_str, EX_we, stall_M;
    logic [4:0]      EX_rd;
    logic            EX_taken, stall_EX;
    logic [XLEN-1:0] EX_target, M_res, M_sd;
    logic [4:0]      M_rd;
    logic            M_ld, M_str, M_we;

    int n_cmp = 0;
    int n_bad = 0;

    ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_a(EX_a), .EX_b(EX_b), .EX_a2(EX_a2), .EX_b2(EX_b2),
        .EX_alu_op(EX_alu_op), .EX_brn(EX_brn), .EX_rd(EX_rd),
        .EX_ld(EX_ld), .EX_str(EX_str), .EX_we(EX_we), .stall_M(stall_M),
        .EX_taken(EX_taken), .EX_target(EX_target), .stall_EX(stall_EX),
        .M_res(M_res), .M_sd(M_sd), .M_rd(M_rd),
        .M_ld(M_ld), .M_str(M_str), .M_we(M_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  sh;
        logic [63:0] prod;
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return $unsigned($signed(a) >>> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] op, input logic [31:0] x,
                                      input logic [31:0] y);
        case (op)
            4'd0: return x == y;
            4'd1: return x != y;
            4'd2: return $signed(x) < $signed(y);
            4'd3: return $signed(x) >= $signed(y);
            4'd4: return x < y;
            4'd5: return x >= y;
            4'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic brn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] a2, input logic [31:0] b2,
                         input logic [4:0] rd, input logic ld, input logic str, input logic we);
        EX_alu_op = op; EX_brn = brn; EX_a = a; EX_b = b; EX_a2 = a2; EX_b2 = b2;
        EX_rd = rd; EX_ld = ld; EX_str = str; EX_we = we;
    endtask

    task automatic chk_bubble(input string tag);
        chk(tag, {M_res, M_sd, M_rd, M_ld, M_str, M_we}, 96'd0);
    endtask

    // Counts cycles with stall_EX high (stall_M low), checking a bubble at each edge.
    task automatic wait_done(output int highs);
        highs = 0;
        while (stall_EX === 1'b1 && highs < 100) begin
            highs++;
            @(posedge clk); #1;
            chk_bubble("bubble");
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic brn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] a2, input logic [31:0] b2,
                          input logic [4:0] rd, input logic ld, input logic str, input logic we);
        logic [31:0] exp_res;
        logic        mdu;
        int          highs;
        mdu = !brn && (op >= 4'd10) && (op <= 4'd12);
        drive(op, brn, a, b, a2, b2, rd, ld, str, we);
        #1;
        if (brn) begin
            exp_res = a + b;
            chk("EX_taken", EX_taken, ref_cond(op, a2, b2));
            chk("EX_target", EX_target, exp_res);
        end else if (ld || str) begin
            exp_res = a + b;
        end else begin
            exp_res = ref_alu(op, a, b);
        end
        if (mdu) begin
            wait_done(highs);
            chk("mdu_stall_cycles", highs, MDU_STALL);
        end else begin
            chk("stall_EX_single", stall_EX, 1'b0);
        end
        @(posedge clk); #1;
        chk("M_res", M_res, exp_res);
        chk("M_rd_we", {M_rd, M_we}, {rd, we});
        chk("M_ld_str", {M_ld, M_str}, {ld, str});
        if (str) chk("M_sd", M_sd, b2);
    endtask

    initial begin
        int          highs, h2;
        int          r;
        logic [3:0]  op;
        logic [31:0] ra, rb, ra2, rb2;

        rst_n = 1'b0; stall_M = 1'b0;
        drive(4'd0, 1'b0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_bubble("reset_M");
        chk("reset_stall_EX", stall_EX, 1'b0);
        rst_n = 1'b1;

        // Directed cases
        run_op(4'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 0, 0, 5'd3, 1'b0, 1'b0, 1'b1);
        run_op(4'd0, 1'b1, 32'h100, 32'h20, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op(4'd0, 1'b1, 32'h100, 32'h20, 32'd9, 32'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op(4'd10, 1'b0, 32'd7, 32'd6, 0, 0, 5'd4, 1'b0, 1'b0, 1'b1);
        run_op(4'd11, 1'b0, 32'd43, 32'd5, 0, 0, 5'd5, 1'b0, 1'b0, 1'b1);
        run_op(4'd12, 1'b0, 32'd43, 32'd5, 0, 0, 5'd6, 1'b0, 1'b0, 1'b1);
        run_op(4'd11, 1'b0, 32'h1234, 32'd0, 0, 0, 5'd7, 1'b0, 1'b0, 1'b1);
        run_op(4'd12, 1'b0, 32'h1234, 32'd0, 0, 0, 5'd8, 1'b0, 1'b0, 1'b1);
        run_op(4'd0, 1'b0, 32'h1000, 32'h10, 0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
        run_op(4'd7, 1'b0, 32'h8000_0000, 32'd31, 0, 0, 5'd1, 1'b0, 1'b0, 1'b1);
        run_op(4'd8, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd2, 1'b0, 1'b0, 1'b1);

        // Downstream stall mid-MUL, with a branch presented while stalled
        drive(4'd10, 1'b0, 32'd7, 32'd6, 0, 0, 5'd9, 1'b0, 1'b0, 1'b1);
        #1;
        highs = 0;
        repeat (5) begin
            chk("mul_stall_EX", stall_EX, 1'b1);
            highs++;
            @(posedge clk); #1;
            chk_bubble("mul_bubble");
        end
        stall_M = 1'b1; EX_brn = 1'b1; EX_alu_op = 4'd6;
        #1;
        repeat (3) begin
            chk("taken_under_stall_M", EX_taken, 1'b0);
            chk("stall_EX_under_stall_M", stall_EX, 1'b1);
            @(posedge clk); #1;
            chk_bubble("M_hold");
        end
        stall_M = 1'b0;
        drive(4'd10, 1'b0, 32'd7, 32'd6, 0, 0, 5'd9, 1'b0, 1'b0, 1'b1);
        #1;
        wait_done(h2);
        chk("mul_delay_cycles", highs + h2, MDU_STALL);
        // Hold in DONE
        stall_M = 1'b1;
        #1;
        repeat (2) begin
            chk("done_stall_EX", stall_EX, 1'b1);
            @(posedge clk); #1;
            chk("done_M_we_hold", M_we, 1'b0);
        end
        stall_M = 1'b0;
        #1;
        chk("done_release_stall_EX", stall_EX, 1'b0);
        @(posedge clk); #1;
        chk("mul_stalled_res", {M_res, M_rd, M_we}, {32'd42, 5'd9, 1'b1});

        // Reset during BUSY
        drive(4'd11, 1'b0, 32'd100, 32'd7, 0, 0, 5'd10, 1'b0, 1'b0, 1'b1);
        #1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(4'd0, 1'b0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_bubble("midop_reset_M");
        chk("midop_reset_stall_EX", stall_EX, 1'b0);
        run_op(4'd0, 1'b0, 32'd20, 32'd22, 0, 0, 5'd11, 1'b0, 1'b0, 1'b1);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            r   = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            ra2 = $urandom;
            rb2 = ($urandom_range(0, 2) == 0) ? ra2 : $urandom;
            if (r < 3) begin
                op = 4'($urandom_range(0, 15));
                run_op(op, 1'b1, ra, rb, ra2, rb2, 5'($urandom), 1'b0, 1'b0, 1'($urandom));
            end else if (r == 3) begin
                if ($urandom_range(0, 1) == 0)
                    run_op(4'd0, 1'b0, ra, rb, 0, rb2, 5'($urandom), 1'b1, 1'b0, 1'b1);
                else
                    run_op(4'd0, 1'b0, ra, rb, 0, rb2, 5'd0, 1'b0, 1'b1, 1'b0);
            end else if (r < 6) begin
                op = 4'(10 + $urandom_range(0, 2));
                case ($urandom_range(0, 3))
                    0: rb = 32'd0;
                    1: rb = 32'($urandom_range(1, 255));
                    default: ;
                endcase
                run_op(op, 1'b0, ra, rb, 0, 0, 5'($urandom), 1'b0, 1'b0, 1'b1);
            end else begin
                op = 4'($urandom_range(0, 15));
                if (op >= 4'd10 && op <= 4'd12) op = 4'd13;
                run_op(op, 1'b0, ra, rb, 0, 0, 5'($urandom), 1'b0, 1'b0, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Sits directly downstream of the decode-to-execute pipeline register and consumes its EX_* outputs.
- Computes ALU results and resolves branches, driving EX_taken and EX_target back to fetch and the decode-to-execute register.
- Runs iterative MUL/DIVU/REMU through an internal FSM, asserting stall_EX while busy.
- Registers results into the EX-to-MEM pipeline outputs (M_*).

Parameters:
XLEN, 32, datapath width; must be a power of two, at least 8.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  synchronous, active-low reset.
EX_a  in  XLEN  ALU operand A.
EX_b  in  XLEN  ALU operand B.
EX_a2  in  XLEN  branch compare operand 1.
EX_b2  in  XLEN  branch compare operand 2; store data when EX_str=1.
EX_alu_op  in  4  ALU opcode, or branch condition when EX_brn=1.
EX_brn  in  1  instruction is a branch/jump.
EX_rd  in  5  destination register.
EX_ld  in  1  load.
EX_str  in  1  store.
EX_we  in  1  register write enable.
stall_M  in  1  downstream stall; freezes this stage.
EX_taken  out  1  branch taken; combinational, valid in the branch's EX cycle.
EX_target  out  XLEN  branch target, EX_a+EX_b mod 2^XLEN; combinational.
stall_EX  out  1  stage busy; upstream must hold its EX_* inputs.
M_res  out  XLEN  registered result or address.
M_sd  out  XLEN  registered store data.
M_rd  out  5  registered destination.
M_ld  out  1  registered load flag.
M_str  out  1  registered store flag.
M_we  out  1  registered write enable.

Behaviour:
- Reset (rst_n=0 at posedge): all M_* outputs 0; FSM to IDLE; iteration counter and operand/partial registers 0. Applies mid-operation; any in-flight MUL/DIV is discarded.
- Opcodes when EX_brn=0:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is EX_b[log2(XLEN)-1:0].
  - 8 SLT (signed), 9 SLTU: result is 0 or 1, zero-extended.
  - 10 MUL: low XLEN bits of the product. 11 DIVU: quotient. 12 REMU: remainder.
  - 13-15: result 0.
- Opcodes when EX_brn=1 (compare EX_a2 vs EX_b2):
  - 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 always.
  - 7-15: never taken.
  - M_res = EX_target.
- Single-cycle ops, when not stalled: M_* loaded at the next edge. Latency is 1 cycle.
- EX_taken = EX_brn & cond & ~stall_M. It is a 1-cycle pulse per branch; upstream flushes on it.
- Multi-cycle FSM states: IDLE, BUSY, DONE.
  - IDLE with opcode 10/11/12, EX_brn=0, stall_M=0: latch operands and EX_rd/EX_we; counter=XLEN; go BUSY; stall_EX=1 this cycle.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide); counter decrements; after XLEN steps go DONE; stall_EX=1 throughout.
  - DONE: stall_EX=0; M_* loaded from the latched result at this edge; go IDLE.
  - Total occupancy is XLEN+2 cycles. The result appears on M_* at the edge ending DONE.
- Division by zero: DIVU gives all ones; REMU gives the dividend. No exception.
- While stall_EX=1 (not DONE) and stall_M=0: M_* loads a bubble (ld/str/we=0, rd=0, res/sd=0) each edge.
- stall_M=1:
  - M_* hold.
  - FSM and counter hold.
  - stall_EX=1 (stall_EX = stall_M | IDLE-start | BUSY).
  - EX_taken=0.
- stall_M asserted in DONE: stay DONE until stall_M drops, then load M_*.
- EX_ld/EX_str: M_res = EX_a+EX_b (address); M_sd = EX_b2. A multi-cycle opcode combined with ld/str is illegal and not checked.

Test Plan:
- ADD: EX_a=5, EX_b=0xFFFFFFFF, EX_rd=3, EX_we=1 -> next edge M_res=4, M_rd=3, M_we=1; stall_EX never 1.
- BEQ: EX_brn=1, op=0, EX_a2=EX_b2=9, EX_a=0x100, EX_b=0x20 -> same cycle EX_taken=1, EX_target=0x120. Repeat with EX_b2=8 -> EX_taken=0.
- MUL 7*6, XLEN=32:
  - stall_EX high for 33 cycles.
  - M_* bubbles during stall.
  - M_res=42, M_we=1 after the edge ending DONE (34th cycle).
  - DIVU 43/5 -> 8; REMU 43/5 -> 3.
- DIVU 0x1234/0 -> M_res=0xFFFFFFFF. REMU 0x1234/0 -> M_res=0x1234.
- stall_M held 3 cycles mid-MUL:
  - counter and M_* frozen.
  - EX_taken=0 for a concurrent branch.
  - completion delayed by exactly 3 cycles, result unchanged.
- rst_n=0 for 1 cycle during BUSY -> all M_*=0, stall_EX=0 next cycle (IDLE, no new op); a following ADD completes in 1 cycle.
